// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs decoded fields plus a sign-extended
// immediate into a 32-bit word and tags it with its instruction-memory address.
module instr_encoder #(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  input  logic                  addr_clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_err,
  output logic [7:0]            err_count
);

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_t;

  localparam logic [31:0]           NOP_WORD  = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

  fmt_t                  fmt;
  logic                  imm_ok;
  logic [31:0]           packed_word;
  logic                  enc_err;
  logic [31:0]           enc_word;
  logic                  in_xfer;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] tag_addr;

  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b1100011:                         fmt = FMT_B;
      7'b0110111, 7'b0010111:             fmt = FMT_U;
      7'b1101111:                         fmt = FMT_J;
      7'b0110011:                         fmt = FMT_R;
      default:                            fmt = FMT_BAD;
    endcase
  end

  // An immediate is encodable only if the format's field width reproduces it exactly.
  always_comb begin
    imm_ok = 1'b0;
    case (fmt)
      FMT_R:        imm_ok = 1'b1;
      FMT_I, FMT_S: imm_ok = (imm == {{20{imm[11]}}, imm[11:0]});
      FMT_B:        imm_ok = !imm[0] && (imm == {{19{imm[12]}}, imm[12:0]});
      FMT_J:        imm_ok = !imm[0] && (imm == {{11{imm[20]}}, imm[20:0]});
      FMT_U:        imm_ok = (imm[11:0] == 12'd0);
      default:      imm_ok = 1'b0;
    endcase
  end

  always_comb begin
    packed_word = 32'd0;
    case (fmt)
      FMT_R: packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: packed_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: packed_word = {imm[31:12], rd, opcode};
      FMT_J: packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: packed_word = 32'd0;
    endcase
  end

  assign enc_err  = !imm_ok;
  assign enc_word = enc_err ? NOP_WORD : packed_word;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  // A clear in the transfer cycle re-bases the word that is being accepted.
  assign tag_addr = addr_clear ? BASE_ADDR : next_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      instr      <= 32'd0;
      instr_addr <= '0;
      instr_err  <= 1'b0;
    end else if (in_xfer) begin
      out_valid  <= 1'b1;
      instr      <= enc_word;
      instr_addr <= tag_addr;
      instr_err  <= enc_err;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr <= BASE_ADDR;
    end else if (in_xfer) begin
      next_addr <= tag_addr + ADDR_STEP;
    end else if (addr_clear) begin
      next_addr <= BASE_ADDR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (in_xfer && enc_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal cases plus randomized
// traffic scored against an arithmetic model of the encoding rules.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        addr_clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr;
  logic [3:0]  instr_addr;
  logic        instr_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  addr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   model_next = 0;
  int   model_errs = 0;
  bit   check_en   = 1'b0;
  bit   rand_ready = 1'b0;

  instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .addr_clear(addr_clear), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .instr_addr(instr_addr), .instr_err(instr_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference encoder: bit 32 is the error flag, bits 31:0 the emitted word.
  function automatic logic [32:0] model_encode(input logic [6:0] op, input logic [4:0] f_rd,
      input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    int s;
    bit ok;
    logic [31:0] w, o, d, r1, r2, fn3, fn7;
    s   = $signed(im);
    o   = 32'(op);
    d   = 32'(f_rd) << 7;
    r1  = 32'(f_rs1) << 15;
    r2  = 32'(f_rs2) << 20;
    fn3 = 32'(f3) << 12;
    fn7 = 32'(f7) << 25;
    ok  = 1'b1;
    w   = 32'd0;
    case (op)
      7'h03, 7'h13, 7'h67: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((im & 32'hFFF) << 20) | r1 | fn3 | d | o;
      end
      7'h23: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((im >> 5) & 32'h7F) << 25) | r2 | r1 | fn3 | ((im & 32'h1F) << 7) | o;
      end
      7'h63: begin
        ok = ((im & 32'd1) == 0) && (s >= -4096) && (s <= 4095);
        w  = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2 | r1 | fn3 |
             (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'd1) << 7) | o;
      end
      7'h37, 7'h17: begin
        ok = ((im & 32'hFFF) == 0);
        w  = (im & 32'hFFFF_F000) | d | o;
      end
      7'h6F: begin
        ok = ((im & 32'd1) == 0) && (s >= -(1 << 20)) && (s <= (1 << 20) - 1);
        w  = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
             (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'hFF) << 12) | d | o;
      end
      7'h33: w = fn7 | r2 | r1 | fn3 | d | o;
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h0000_0013;
    return {!ok, w};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] f_rd, input logic [4:0] f_rs1,
      input logic [4:0] f_rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] im, input logic clr);
    bit done;
    int n;
    opcode = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2; funct3 = f3; funct7 = f7; imm = im;
    addr_clear = clr;
    in_valid   = 1'b1;
    done = 1'b0;
    n    = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake timeout: in_ready stayed %b want 1", in_ready);
    end
    in_valid   = 1'b0;
    addr_clear = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard: the queue head is the word that must currently sit on the output.
  always @(negedge clk) begin
    logic [32:0] e;
    logic [3:0]  tag;
    bit          exp_ready;
    if (rst_n && check_en) begin
      exp_ready = (exp_q.size() == 0) || out_ready;
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("[TB] FAIL out_valid: got %b want %b", out_valid, exp_q.size() != 0);
      end
      if (out_valid && exp_q.size() != 0) begin
        checks++;
        if (instr !== exp_q[0].word || instr_addr !== exp_q[0].addr || instr_err !== exp_q[0].err) begin
          errors++;
          $display("[TB] FAIL out_word: got instr=%h addr=%h err=%b want instr=%h addr=%h err=%b",
                   instr, instr_addr, instr_err, exp_q[0].word, exp_q[0].addr, exp_q[0].err);
        end
      end
      checks++;
      if (err_count !== 8'(model_errs)) begin
        errors++;
        $display("[TB] FAIL err_count: got %0d want %0d", err_count, model_errs);
      end
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL in_ready: got %b want %b", in_ready, exp_ready);
      end
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ready) begin
        e   = model_encode(opcode, rd, rs1, rs2, funct3, funct7, imm);
        tag = addr_clear ? 4'd0 : 4'(model_next);
        exp_q.push_back('{word: e[31:0], addr: tag, err: e[32]});
        model_next = (int'(tag) + 4) % 16;
        if (e[32] && model_errs < 255) model_errs++;
      end else if (addr_clear) begin
        model_next = 0;
      end
    end
  end

  logic [6:0] valid_ops [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    logic [32:0] e;
    logic [31:0] r, im;
    logic [6:0]  op;
    int          k;

    $display("[TB] start");
    e = model_encode(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    checkOutput("model jal", e[31:0], 32'h0010_00EF);
    e = model_encode(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    checkOutput("model lui", e[31:0], 32'h1234_52B7);
    e = model_encode(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
    checkOutput("model sub", e[31:0], 32'h4020_81B3);
    e = model_encode(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
    checkOutput("model jal range err", 32'(e[32]), 32'd1);

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset instr", instr, 32'd0);
    checkOutput("reset err_count", 32'(err_count), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    rst_n    = 1'b1;
    check_en = 1'b1;

    applyStimulus(7'h03, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FF0F, 1'b0);
    checkOutput("ld instr", instr, 32'hF0F1_0083);
    checkOutput("ld addr", 32'(instr_addr), 32'd0);
    checkOutput("ld err", 32'(instr_err), 32'd0);
    applyStimulus(7'h23, 5'd0, 5'd2, 5'd1, 3'd0, 7'd0, 32'hFFFF_FFE0, 1'b0);
    checkOutput("sd instr", instr, 32'hFE11_0023);
    checkOutput("sd addr", 32'(instr_addr), 32'd4);
    applyStimulus(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_081E, 1'b0);
    checkOutput("beq instr", instr, 32'h0020_8FE3);
    checkOutput("beq addr", 32'(instr_addr), 32'd8);

    applyStimulus(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0801, 1'b0);
    checkOutput("beq odd instr", instr, 32'h0000_0013);
    checkOutput("beq odd err", 32'(instr_err), 32'd1);
    checkOutput("beq odd err_count", 32'(err_count), 32'd1);
    applyStimulus(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b0);
    checkOutput("addi range err", 32'(instr_err), 32'd1);
    checkOutput("addi err_count", 32'(err_count), 32'd2);

    applyStimulus(7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    out_ready = 1'b0;
    opcode = 7'h13; rd = 5'd5; rs1 = 5'd6; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0;
    imm = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall instr held", instr, 32'h0052_0193);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("post-stall instr", instr, 32'hFFF3_0293);

    addr_clear = 1'b1;
    @(posedge clk);
    #1;
    addr_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(7'h37, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 1'b0);
      checkOutput("wrap addr", 32'(instr_addr), 32'((i * 4) % 16));
    end
    applyStimulus(7'h33, 5'd7, 5'd8, 5'd9, 3'd1, 7'd0, 32'd0, 1'b1);
    checkOutput("clear+xfer addr", 32'(instr_addr), 32'd0);
    applyStimulus(7'h33, 5'd7, 5'd8, 5'd9, 3'd1, 7'd0, 32'd0, 1'b0);
    checkOutput("after clear addr", 32'(instr_addr), 32'd4);

    applyStimulus(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0);
    out_ready = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("async rst instr", instr, 32'd0);
    checkOutput("async rst addr", 32'(instr_addr), 32'd0);
    checkOutput("async rst err", 32'(instr_err), 32'd0);
    checkOutput("async rst err_count", 32'(err_count), 32'd0);
    exp_q.delete();
    model_next = 0;
    model_errs = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    applyStimulus(7'h03, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FF0F, 1'b0);
    checkOutput("post-rst instr", instr, 32'hF0F1_0083);
    checkOutput("post-rst addr", 32'(instr_addr), 32'd0);
    checkOutput("post-rst err_count", 32'(err_count), 32'd0);

    rand_ready = 1'b1;
    for (int t = 0; t < 1200; t++) begin
      k  = $urandom_range(0, 11);
      op = (k < 9) ? valid_ops[k] : 7'($urandom);
      r  = $urandom;
      case ($urandom_range(0, 4))
        0:       im = {{20{r[11]}}, r[11:0]};
        1:       im = {{19{r[12]}}, r[12:1], 1'b0};
        2:       im = {{11{r[20]}}, r[20:1], 1'b0};
        3:       im = {r[31:12], 12'd0};
        default: im = r;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                    im, ($urandom_range(0, 19) == 0));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("drain out_valid", 32'(out_valid), 32'd0);
    checkOutput("err_count saturated", 32'(err_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: the inverse of the immediate generator. It accepts decoded fields (opcode, registers, funct codes, and a full 32-bit sign-extended immediate) over a valid/ready handshake. It packs the immediate into the format-specific bit positions and emits a 32-bit instruction word with its instruction-memory address. Used by the test/boot path to load programs into instruction memory and to round-trip check the immediate generator.

## Interface
- ADDR_WIDTH, 10: width of the instruction-memory byte address.
- BASE_ADDR, 0: address assigned to the first word after reset or clear.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept; transfer when in_valid && in_ready.
- opcode  in  7  instruction opcode.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field, used for R-type only.
- imm  in  32  immediate as a sign-extended byte value (same form the immediate generator outputs).
- addr_clear  in  1  synchronous restart of the address counter to BASE_ADDR.
- out_valid  out  1  instr/instr_addr/instr_err valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- instr  out  32  encoded instruction word.
- instr_addr  out  ADDR_WIDTH  byte address of instr.
- instr_err  out  1  this word failed encoding; instr carries a NOP.
- err_count  out  8  saturating count of accepted inputs flagged instr_err.

## Operation
- Formats by opcode:
  - I-type (0000011, 0010011, 1100111): instr[31:20]=imm[11:0].
  - S-type (0100011): [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B-type (1100011): [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U-type (0110111, 0010111): [31:12]=imm[31:12].
  - J-type (1101111): [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - R-type (0110011): [31:25]=funct7; imm ignored.
- Field placement:
  - rd at [11:7] for R/I/U/J; rs1 at [19:15] for R/I/S/B.
  - rs2 at [24:20] for R/S/B; funct3 at [14:12] for R/I/S/B.
  - opcode at [6:0]; field bits unused by a format are 0.
- Range checks (instr_err=1 if any fails):
  - I/S: imm must equal sign-extension of imm[11:0].
  - B: imm[0]==0 and imm fits 13-bit signed.
  - J: imm[0]==0 and imm fits 21-bit signed.
  - U: imm[11:0]==0.
  - Any opcode not listed above is an error.
- On error, instr=32'h00000013 (addi x0,x0,0) and instr_err=1. The word is still emitted, consumes an address, and increments err_count, which saturates at 255.
- Address counter next_addr:
  - Each accepted input is tagged with next_addr, then next_addr += 4, modulo 2^ADDR_WIDTH.
  - addr_clear alone sets next_addr=BASE_ADDR.
  - addr_clear in the same cycle as an input transfer: clear wins. The word gets BASE_ADDR and next_addr becomes BASE_ADDR+4.
- Single output register stage (pipe register, no bubble):
  - in_ready = !out_valid || out_ready.
  - Capture while out_valid && out_ready gives back-to-back throughput.
  - No transfer and no pending output: out_valid falls after the consumer takes the word.

## Timing
- Latency: 1 cycle from input transfer edge to out_valid=1 with the encoded word.
- Throughput: 1 word/cycle while out_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, instr/instr_addr/instr_err hold stable and in_ready=0.
  - The producer must hold its fields while in_valid && !in_ready.
- Reset (rst_n low, asynchronous, any time incl. mid-stall):
  - out_valid=0, instr=0, instr_addr=0, instr_err=0, err_count=0, next_addr=BASE_ADDR.
  - in_ready=1 combinationally from the first cycle after release.
- Reset mid-stall drops the held word; no replay.
- err_count and the address update on the same edge as the input transfer.

## Test plan
- ld, opcode 0000011, rd=1, rs1=2, funct3=0, imm=32'hFFFFFF0F -> instr=32'hF0F10083, instr_addr=0, instr_err=0, one cycle after transfer.
- Back-to-back with out_ready=1:
  - sd, rs1=2, rs2=1, imm=32'hFFFFFFE0 -> 32'hFE110023 @4.
  - beq, rs1=1, rs2=2, imm=32'h0000081E -> 32'h00208FE3 @8.
- Range errors:
  - beq with imm=32'h00000801 (odd) -> instr=32'h00000013, instr_err=1, err_count=1.
  - addi with imm=32'h00000800 -> instr_err=1, err_count=2.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output word held constant. Release -> next word appears the following cycle with no loss or duplicate.
- Address wrap and clear:
  - ADDR_WIDTH=4: five words -> addresses 0,4,8,C,0.
  - addr_clear coincident with a transfer -> that word gets 0, the next gets 4.
- Async reset while out_valid=1 and stalled -> all outputs 0 immediately. After release, the first word gets BASE_ADDR and err_count=0.
